tick_to_level_fsm: RTL and testbench

- Converts single-cycle tick pulses back into clean level pulses. This is the reverse direction of the level-to-tick edge detector.
- Each accepted tick produces one high pulse of fixed width, followed by a guaranteed low gap. A downstream edge detector therefore recovers exactly one tick per input tick.
- Ticks that arrive while a pulse is in progress are queued in a saturating pending counter and replayed in order. Ticks that do not fit are dropped and flagged.

---
 rtl/tick_to_level_fsm_if.sv | 27 ++
 rtl/tick_to_level_fsm.sv | 133 +++++++++++++
 tb/tb_tick_to_level_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tick_to_level_fsm_if.sv
// Signal bundle between a tick source and the tick-to-level stretcher.
// The source drives tick; the stretcher drives level, status and count.
interface tick_to_level_fsm_if #(
  parameter int PEND_W = 3
);
  logic              tick_amisha;
  logic              level_amisha;
  logic              busy_amisha;
  logic              overflow_amisha;
  logic [PEND_W-1:0] pend_cnt_amisha;

  modport master (
    output tick_amisha,
    input  level_amisha,
    input  busy_amisha,
    input  overflow_amisha,
    input  pend_cnt_amisha
  );

  modport slave (
    input  tick_amisha,
    output level_amisha,
    output busy_amisha,
    output overflow_amisha,
    output pend_cnt_amisha
  );
endinterface

// File: rtl/tick_to_level_fsm.sv
// Stretches single-cycle ticks into fixed-width level pulses with a
// guaranteed low gap; ticks arriving mid-pulse are queued and replayed.
module tick_to_level_fsm #(
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 2,
  parameter int PEND_W   = 3
) (
  input logic                clk_amisha,
  input logic                reset_amisha,
  tick_to_level_fsm_if.slave bus
);

  localparam int MAXC  = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0]  HI_LD = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0]  LO_LD = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
  localparam logic [PEND_W-1:0] P_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] P_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PEND_W-1:0] pend, pend_n;
  logic              ovf_n;
  logic              q_tick;
  logic              rep;
  logic              level_q;
  logic              busy_q;
  logic              ovf_q;
  logic              tick;

  assign tick = bus.tick_amisha;

  // State, counters and registered outputs.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      level_q <= (state_n == HIGH);
      busy_q  <= (state_n != IDLE) || (pend_n != '0);
      ovf_q   <= ovf_n;
    end
  end

  // Next state, counter reload and queue/replay decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_tick  = 1'b0;
    rep     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        cnt_n = '0;
        if (tick) begin
          state_n = HIGH;
          cnt_n   = HI_LD;
        end else if (pend != '0) begin
          state_n = HIGH;
          cnt_n   = HI_LD;
          rep     = 1'b1;
        end
      end
      (state == HIGH): begin
        q_tick = tick;
        if (cnt == '0) begin
          state_n = LOW;
          cnt_n   = LO_LD;
        end else begin
          cnt_n = cnt - C_ONE;
        end
      end
      (state == LOW): begin
        if (cnt == '0) begin
          if (pend != '0) begin
            state_n = HIGH;
            cnt_n   = HI_LD;
            rep     = 1'b1;
            q_tick  = tick;
          end else if (tick) begin
            state_n = HIGH;
            cnt_n   = HI_LD;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n  = cnt - C_ONE;
          q_tick = tick;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pending counter: a queued tick and a replay in one cycle cancel out.
  always_comb begin
    pend_n = pend;
    ovf_n  = 1'b0;
    if (q_tick && !rep) begin
      if (pend == P_MAX) begin
        ovf_n = 1'b1;
      end else begin
        pend_n = pend + P_ONE;
      end
    end else if (rep && !q_tick) begin
      pend_n = pend - P_ONE;
    end
  end

  assign bus.level_amisha    = level_q;
  assign bus.busy_amisha     = busy_q;
  assign bus.overflow_amisha = ovf_q;
  assign bus.pend_cnt_amisha = pend;

endmodule

// File: tb/tb_tick_to_level_fsm.sv
// Bench for tick_to_level_fsm: pulse-schedule reference model,
// directed scenarios, then a random loopback through an edge detector.
module tb_tick_to_level_fsm;

  localparam int H    = 4;
  localparam int L    = 2;
  localparam int PW   = 3;
  localparam int P    = H + L;
  localparam int PMAX = (1 << PW) - 1;

  logic clk;
  logic rst;

  tick_to_level_fsm_if #(.PEND_W(PW)) bus ();

  tick_to_level_fsm #(
    .HIGH_CYC(H),
    .LOW_CYC (L),
    .PEND_W  (PW)
  ) dut (
    .clk_amisha  (clk),
    .reset_amisha(rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted tick is assigned a pulse start
  // edge; pulses start no sooner than P edges after the previous one.
  int q[$];
  int cur_s  = -1000;
  int last_s = -1000;
  int e      = 0;
  int m_ovf  = 0;
  int acc    = 0;
  int det    = 0;
  int ovf_n  = 0;
  int pk_dut = 0;
  int pk_mod = 0;
  logic lvl_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d got %0d exp %0d", tag, e, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic r);
    int s;
    @(negedge clk);
    bus.tick_amisha = t;
    rst = r;
    @(posedge clk);
    e++;
    m_ovf = 0;
    if (r) begin
      q.delete();
      cur_s  = -1000;
      last_s = -1000;
    end else begin
      if (q.size() > 0 && q[0] <= e) cur_s = q.pop_front();
      if (t) begin
        if (q.size() >= PMAX) begin
          m_ovf = 1;
        end else begin
          s = (last_s + P > e) ? last_s + P : e;
          last_s = s;
          acc++;
          if (s == e) cur_s = s;
          else q.push_back(s);
        end
      end
    end
    #1;
    chk("level", int'(bus.level_amisha),
        int'(e >= cur_s && e < cur_s + H));
    chk("pend", int'(bus.pend_cnt_amisha), q.size());
    chk("busy", int'(bus.busy_amisha), int'(e < last_s + P));
    chk("overflow", int'(bus.overflow_amisha), m_ovf);
    if (bus.level_amisha && !lvl_prev) det++;
    lvl_prev = bus.level_amisha;
    if (bus.overflow_amisha) ovf_n++;
    if (int'(bus.pend_cnt_amisha) > pk_dut) pk_dut = int'(bus.pend_cnt_amisha);
    if (q.size() > pk_mod) pk_mod = q.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    bus.tick_amisha = 1'b0;

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0);
    idle(10);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle(24);

    pk_dut = 0;
    pk_mod = 0;
    ovf_n  = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("burst_pend_peak", pk_dut, pk_mod);
    chk("burst_pend_sat", pk_dut, PMAX);
    idle(70);
    chk("burst_busy_drain", int'(bus.busy_amisha), 0);

    step(1'b1, 1'b0);
    idle(P - 1);
    step(1'b1, 1'b0);
    idle(12);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("rst_level", int'(bus.level_amisha), 0);
    chk("rst_pend", int'(bus.pend_cnt_amisha), 0);
    chk("rst_busy", int'(bus.busy_amisha), 0);
    det = 0;
    idle(20);
    chk("rst_no_pulses", det, 0);

    det   = 0;
    ovf_n = 0;
    a0    = acc;
    for (int i = 0; i < 400; i++) begin
      if (q.size() < PMAX - 1 && $urandom_range(2) == 0)
        step(1'b1, 1'b0);
      else
        step(1'b0, 1'b0);
    end
    idle(P * (PMAX + 2));
    chk("loop_tick_count", det, acc - a0);
    chk("loop_no_overflow", ovf_n, 0);
    chk("loop_idle", int'(bus.busy_amisha), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
